// File: rtl/bitslam_host.sv
// Host-side driver for the bitslam chip register bus: buffers (addr, data) writes,
// generates the chip clock and serialises writes into address/data bus phases.
package bitslam_host_pkg;

    localparam int unsigned FIELD_W = 6;

    typedef struct packed {
        logic [FIELD_W-1:0] addr;
        logic [FIELD_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [FIELD_W-1:0] addr_data;
        logic               sel;
    } bus_t;

endpackage

module bitslam_host
    import bitslam_host_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [5:0]   wr_addr,
    input  logic [5:0]   wr_data,
    output logic [7:0]   chip_io_in,
    input  logic [7:0]   chip_io_out,
    output logic         audio_out,
    output logic         idle
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [FIELD_W-1:0] RST_ADDR  = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Chip clock generation
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] half_cnt;
    logic             chip_clk;
    logic             boundary_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            chip_clk <= 1'b0;
        end else if (half_cnt == DIV_LAST) begin
            half_cnt <= '0;
            chip_clk <= ~chip_clk;
        end else begin
            half_cnt <= half_cnt + DIV_W'(1);
        end
    end

    // Phase boundary: the cycle in which the chip clock falls.
    assign boundary_c = chip_clk && (half_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Write-request FIFO
    // ------------------------------------------------------------------
    wr_req_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             push_c;
    logic             pop_c;
    logic             empty_c;
    wr_req_t          head_c;

    assign push_c  = wr_valid && wr_ready;
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];
    assign count_n = count + CNT_W'(push_c) - CNT_W'(pop_c);

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_n;
            wr_ready <= (count_n != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencing FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_n;
    bus_t             bus;
    bus_t             bus_n;
    logic [FIELD_W-1:0] last_addr;
    logic [FIELD_W-1:0] last_addr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Same-address writes go straight to a data phase; otherwise an address phase first.
    always_comb begin
        state_n     = state;
        bus_n       = bus;
        last_addr_n = last_addr;
        pop_c       = 1'b0;
        if (boundary_c) begin
            case (state)
                ST_ADDR: begin
                    if (!empty_c) begin
                        state_n = ST_DATA;
                        pop_c   = 1'b1;
                        bus_n   = '{addr_data: head_c.data, sel: 1'b1};
                    end else begin
                        state_n = ST_IDLE;
                        bus_n   = '{addr_data: last_addr, sel: 1'b0};
                    end
                end
                default: begin
                    if (empty_c) begin
                        state_n = ST_IDLE;
                        bus_n   = '{addr_data: last_addr, sel: 1'b0};
                    end else if (head_c.addr == last_addr) begin
                        state_n = ST_DATA;
                        pop_c   = 1'b1;
                        bus_n   = '{addr_data: head_c.data, sel: 1'b1};
                    end else begin
                        state_n     = ST_ADDR;
                        bus_n       = '{addr_data: head_c.addr, sel: 1'b0};
                        last_addr_n = head_c.addr;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus       <= '{addr_data: RST_ADDR, sel: 1'b0};
            last_addr <= RST_ADDR;
            idle      <= 1'b1;
        end else begin
            bus       <= bus_n;
            last_addr <= last_addr_n;
            idle      <= (count_n == '0) && (state_n == ST_IDLE);
        end
    end

    assign chip_io_in = {bus, chip_clk};

    // ------------------------------------------------------------------
    // Audio return path synchroniser
    // ------------------------------------------------------------------
    logic audio_meta;
    logic unused_io;

    assign unused_io = ^chip_io_out[7:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_meta <= 1'b0;
            audio_out  <= 1'b0;
        end else begin
            audio_meta <= chip_io_out[0];
            audio_out  <= audio_meta;
        end
    end

endmodule

// File: tb/tb_bitslam_host.sv
// Directed bench for bitslam_host with a behavioural chip model that latches
// addresses and register writes on rising chip-clock edges.
module tb_bitslam_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic [7:0] chip_io_in;
    logic [7:0] chip_io_out;
    logic       audio_out;
    logic       idle;

    int total = 0;
    int bad   = 0;

    bitslam_host #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .chip_io_in  (chip_io_in),
        .chip_io_out (chip_io_out),
        .audio_out   (audio_out),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    // Chip model: reg 0 = max_clk_div, reg 1 = tap_mask
    logic [5:0] chip_regs [64];
    logic [5:0] chip_addr = 6'h3F;
    logic [6:0] plog [$];
    logic [6:0] exp_q [$];
    logic [6:0] skip_val = 7'h7E;
    bit         logging = 1'b0;

    always @(posedge chip_io_in[0]) begin
        if (logging && !(plog.size() == 0 && chip_io_in[7:1] == skip_val))
            plog.push_back(chip_io_in[7:1]);
        if (chip_io_in[1])
            chip_regs[chip_addr] = chip_io_in[7:2];
        else
            chip_addr = chip_io_in[7:2];
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int log_at(input int i);
        if (i < plog.size()) return int'(plog[i]);
        return -1;
    endfunction

    task automatic start_log();
        skip_val = chip_io_in[7:1];
        plog.delete();
        logging = 1'b1;
    endtask

    task automatic check_log(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_ph%0d", tag, i), log_at(i), int'(exp_q[i]));
        logging = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [5:0] d);
        int n;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        if (!wr_ready) chk("wr_accept_timeout", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && !idle; i++) tick();
        chk(tag, int'(idle), 1);
        repeat (10) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) chip_regs[i] = 6'h00;
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = 6'h00;
        wr_data     = 6'h00;
        chip_io_out = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_io_in", int'(chip_io_in), 'hFC);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_idle", int'(idle), 1);
        chk("rst_audio", int'(audio_out), 0);

        // Free-running chip clock while idle
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("clk_k%0d", k), int'(chip_io_in), int'({7'h7E, 1'((k / 2) & 1)}));
        end
        chk("clk_idle", int'(idle), 1);
        chk("clk_ready", int'(wr_ready), 1);

        // Single write (0,5)
        start_log();
        wr(6'd0, 6'd5);
        wait_idle("t1_idle");
        exp_q = '{7'h00, 7'h0B, 7'h00};
        check_log("t1");
        chk("t1_max_clk_div", int'(chip_regs[0]), 5);

        // Same-address writes (1,3),(1,6)
        start_log();
        wr(6'd1, 6'd3);
        wr(6'd1, 6'd6);
        wait_idle("t2_idle");
        exp_q = '{7'h02, 7'h07, 7'h0D, 7'h02};
        check_log("t2");
        chk("t2_tap_mask", int'(chip_regs[1]), 6);

        // Alternating addresses (0,2),(1,7),(0,9)
        start_log();
        wr(6'd0, 6'd2);
        wr(6'd1, 6'd7);
        wr(6'd0, 6'd9);
        wait_idle("t3_idle");
        exp_q = '{7'h00, 7'h05, 7'h02, 7'h0F, 7'h00, 7'h13, 7'h00};
        check_log("t3");
        chk("t3_max_clk_div", int'(chip_regs[0]), 9);
        chk("t3_tap_mask", int'(chip_regs[1]), 7);

        // FIFO fill: four accepted, fifth waits for the first pop
        start_log();
        wr(6'd2, 6'd1);
        wr(6'd2, 6'd2);
        wr(6'd3, 6'd3);
        wr(6'd3, 6'd4);
        chk("t4_full_ready", int'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_addr  = 6'd4;
        wr_data  = 6'd5;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        chk("t4_waited", int'(n > 0), 1);
        chk("t4_pop_bus", int'(chip_io_in[7:1]), 'h03);
        tick();
        wr_valid = 1'b0;
        wait_idle("t4_idle");
        exp_q = '{7'h04, 7'h03, 7'h05, 7'h06, 7'h07, 7'h09, 7'h08, 7'h0B, 7'h08};
        check_log("t4");
        chk("t4_reg3", int'(chip_regs[3]), 4);
        chk("t4_reg4", int'(chip_regs[4]), 5);

        // Reset during a data phase
        wr(6'd2, 6'd5);
        wr(6'd2, 6'd6);
        n = 0;
        while (!chip_io_in[1] && n < 200) begin
            tick();
            n++;
        end
        chk("t5_in_data", int'(chip_io_in[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_io_in", int'(chip_io_in), 'hFC);
        chk("t5_rst_idle", int'(idle), 1);
        chk("t5_rst_ready", int'(wr_ready), 1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        start_log();
        wr(6'd0, 6'd1);
        wait_idle("t5_idle");
        exp_q = '{7'h00, 7'h03, 7'h00};
        check_log("t5");
        chk("t5_max_clk_div", int'(chip_regs[0]), 1);

        // Audio synchroniser latency; upper io_out bits are ignored
        chip_io_out = 8'hFE;
        repeat (3) tick();
        chk("au_low", int'(audio_out), 0);
        chip_io_out = 8'h01;
        tick();
        chk("au_lat1", int'(audio_out), 0);
        tick();
        chk("au_lat2", int'(audio_out), 1);
        chip_io_out = 8'h00;
        tick();
        chk("au_fall1", int'(audio_out), 1);
        tick();
        chk("au_fall2", int'(audio_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitslam_host.md
Name: bitslam_host

Overview:
- Host-side driver for the bitslam chip's 8-bit io_in register bus.
- Accepts (addr, data) register-write requests over a valid/ready handshake and buffers them in a small FIFO.
- Generates the chip's free-running clock and serialises each write into address and data bus phases.
- Returns the chip's 1-bit audio output, synchronised into the host clock domain.

Parameters:
- CLK_DIV, 2, host clocks per chip-clock half period; legal range 1..255.
- FIFO_DEPTH, 4, write-request FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  host clock
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  write request valid
- wr_ready  output  1  request accepted when wr_valid & wr_ready; equals !fifo_full
- wr_addr  input  6  chip register address
- wr_data  input  6  chip register data
- chip_io_in  output  8  to chip io_in: [0]=chip clock, [1]=addr/data select, [7:2]=addr/data
- chip_io_out  input  8  from chip io_out; only bit 0 (audio) is used
- audio_out  output  1  chip_io_out[0] after a 2-flop synchroniser
- idle  output  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - half_cnt=0, chip_clk=0, FSM=IDLE, last_addr=6'h3F, FIFO empty.
  - chip_io_in=8'hFC, wr_ready=1, audio_out=0, idle=1.
- Chip clock generation:
  - half_cnt counts 0..CLK_DIV-1. On the cycle half_cnt==CLK_DIV-1 it wraps to 0 and chip_clk toggles.
  - Chip clock period is 2*CLK_DIV host cycles and runs continuously, including when idle.
- Phase boundary: the host cycle where chip_clk toggles 1->0.
  - The FSM advances and chip_io_in[7:1] update only on phase boundaries, so the bus is stable for a full period around each chip rising edge.
  - chip_io_in[0]=chip_clk; all chip_io_in bits are registered.
- Bus encoding:
  - sel=0: chip latches addr_data as its address.
  - sel=1: chip writes addr_data as data to the current address.
- FSM states. At each phase boundary, "head" is the FIFO head:
  - IDLE: bus={last_addr,0}.
    - FIFO empty -> stay IDLE.
    - Else if head.addr==last_addr -> DATA (pop head, bus={head.data,1}).
    - Else -> ADDR (bus={head.addr,0}, last_addr<=head.addr, no pop).
  - ADDR -> DATA: pop head, bus={head.data,1}.
  - DATA: same rules as IDLE. FIFO empty -> IDLE with bus={last_addr,0}.
- Repeated address phases in idle rewrite the same address and are harmless.
- Consecutive writes to the same address skip the ADDR phase: one chip cycle per write.
- FIFO:
  - Push on wr_valid & wr_ready.
  - A push and a pop in the same cycle are both performed.
  - No push when full; wr_ready deasserts in the cycle after the push that fills the FIFO.
  - Requests are preserved in order.
- Writes to address 6'h3F are legal and passed through; the chip ignores them.
- audio_out: two-flop synchroniser on chip_io_out[0], 2-cycle latency.
- Reset mid-transaction: everything returns to reset values. A partially sent write is lost; the FIFO is cleared.

Test Plan:
- Reset, CLK_DIV=2, no writes:
  - chip_io_in[0] toggles every 2 cycles.
  - chip_io_in[7:1] stays 7'h7E.
  - idle=1, wr_ready=1.
- Single write (addr=0, data=5):
  - First boundary after push: bus[7:1]=7'h00.
  - Next boundary: bus[7:1]=7'h0B.
  - Next boundary: bus[7:1]=7'h00; idle=1.
  - Bench chip model latches max_clk_div=5.
- Writes (1,3),(1,6) back-to-back: ADDR(1), DATA(3), DATA(6), IDLE. Exactly 3 bus phases; the chip model ends with tap_mask=6.
- Writes (0,2),(1,7),(0,9): ADDR0, DATA2, ADDR1, DATA7, ADDR0, DATA9. The chip model ends with max=9, tap=7.
- Push 5 writes with wr_valid held, FIFO_DEPTH=4:
  - wr_ready drops after the 4th accept, and the 5th waits.
  - The 5th is accepted after the first pop.
  - All 5 appear in order.
- Assert rst_n low during a DATA phase:
  - chip_io_in=8'hFC and the FIFO is empty immediately.
  - After release, a new write (0,1) completes normally.
- Drive chip_io_out[0]=1: audio_out rises exactly 2 cycles later.
